// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// 3-sample majority vote per bit, and parity/framing/break flags reported with every frame.
module uart_rx_cfg #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 57_600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);
    localparam int unsigned BAUD_CNT      = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BAUD_CNT = BAUD_CNT / 2;
    localparam int unsigned CW            = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] FULL_LAST   = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(HALF_BAUD_CNT - 1);
    localparam logic [3:0] DATA_LAST      = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST      = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_WAIT_HIGH, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rx_s_q, rx_s_dly_q;
    logic [2:0]           win_q;
    logic [1:0]           warm_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 hold_q, hold_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;
    logic                 stop0_low_q, stop0_low_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 frerr_q, frerr_d;
    logic                 brk_q, brk_d;
    logic                 dv_q, dv_d;

    logic maj, tick, counting, par_x, first_low;

    assign maj = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
    assign counting = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
    assign tick = (state_q == S_START) ? (cnt_q == HALF_LAST)
                                       : (counting && !hold_q && cnt_q == FULL_LAST);
    assign par_x     = (^shreg_q) ^ par_bit_q;
    assign first_low = (bit_cnt_q == 4'd0) ? !maj : stop0_low_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        ferr_d      = ferr_q;
        stop0_low_d = stop0_low_q;
        data_d      = data_q;
        perr_d      = perr_q;
        frerr_d     = frerr_q;
        brk_d       = brk_q;
        dv_d        = 1'b0;

        case (state_q)
            // warm_q keeps the reset value of the synchroniser from counting as a real high line
            S_WAIT_HIGH: if (warm_q[1] && rx_s_q) state_d = S_IDLE;
            S_IDLE: begin
                if (rx_s_dly_q && !rx_s_q) begin
                    state_d = S_START;
                    ferr_d  = 1'b0;
                end
            end
            S_START: if (tick) state_d = maj ? S_IDLE : S_DATA;
            S_DATA: begin
                if (tick) begin
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_bit_d = maj;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!maj) ferr_d = 1'b1;
                    if (bit_cnt_q == 4'd0) stop0_low_d = !maj;
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = S_DONE;
                        dv_d    = 1'b1;
                        data_d  = shreg_q;
                        perr_d  = (PARITY == 1) ? !par_x : (PARITY == 2) ? par_x : 1'b0;
                        frerr_d = ferr_q | !maj;
                        brk_d   = (shreg_q == '0) && ((PARITY == 0) || !par_bit_q) && first_low;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_DONE:  state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
            default: state_d = S_WAIT_HIGH;
        endcase

        // Each field after a tick spends one extra cycle at count 0, giving BAUD_CNT+1 cycles per bit
        if (state_d != state_q) begin
            cnt_d     = '0;
            bit_cnt_d = '0;
        end else if (counting) begin
            if (tick)         cnt_d = '0;
            else if (!hold_q) cnt_d = cnt_q + 1'b1;
        end
        hold_d = tick && ((state_d == S_DATA) || (state_d == S_PARITY) || (state_d == S_STOP));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_HIGH;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_s_dly_q  <= 1'b1;
            win_q       <= 3'b111;
            warm_q      <= 2'b00;
            cnt_q       <= '0;
            hold_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_bit_q   <= 1'b0;
            ferr_q      <= 1'b0;
            stop0_low_q <= 1'b0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            frerr_q     <= 1'b0;
            brk_q       <= 1'b0;
            dv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            rx_s_dly_q  <= rx_s_q;
            win_q       <= {win_q[1:0], rx_s_q};
            warm_q      <= {warm_q[0], 1'b1};
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_bit_q   <= par_bit_d;
            ferr_q      <= ferr_d;
            stop0_low_q <= stop0_low_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            frerr_q     <= frerr_d;
            brk_q       <= brk_d;
            dv_q        <= dv_d;
        end
    end

    assign data_valid = dv_q;
    assign data       = data_q;
    assign parity_err = perr_q;
    assign frame_err  = frerr_q;
    assign break_det  = brk_q;
endmodule
